// File: rtl/window_edge_detector.sv
// rtl/window_edge_detector.sv - sliding-window sum with centre-sample edge detection
//
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   in_valid, in_data : sample input, accepted whenever in_valid is high (no backpressure)
//   line_start        : with in_valid, the accepted sample starts a new line
//   mode              : 0 = dark-centre detect, 1 = bright-centre detect
//   out_valid,out_data: sample shifted out of the window, one cycle after each accept
//   sum               : exact sum of all window entries
//   window_full       : DEPTH samples accepted since the last line start or reset
//   edge_pulse        : single-cycle edge indication, aligned with the updated sum
//   edge_col          : column of the centre sample at the last edge
//   edge_count        : edges detected in the current line
module window_edge_detector #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 11,
    parameter int THRESH = 3,
    parameter int COL_W  = 10,
    localparam int SUM_W = DATA_W + $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              line_start,
    input  logic              mode,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [SUM_W-1:0]  sum,
    output logic              window_full,
    output logic              edge_pulse,
    output logic [COL_W-1:0]  edge_col,
    output logic [COL_W-1:0]  edge_count
);

    localparam int                 CTR      = DEPTH / 2;
    localparam int                 FILL_W   = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(DEPTH);
    localparam logic [COL_W-1:0]   COL_MAX  = {COL_W{1'b1}};
    localparam logic [SUM_W-1:0]   THRESH_V = SUM_W'(THRESH);

    logic [DATA_W-1:0] win [DEPTH];
    logic [FILL_W-1:0] fill;
    logic [COL_W-1:0]  next_col;   // column the next accepted sample will take

    logic [COL_W-1:0]  cur_col;
    logic [SUM_W-1:0]  shift_sum;
    logic [FILL_W-1:0] fill_nx;
    logic [DATA_W-1:0] centre_nx;
    logic              full_nx;
    logic              edge_nx;

    assign window_full = (fill == FILL_MAX);

    always_comb begin
        cur_col   = line_start ? '0 : next_col;
        // Modular arithmetic in SUM_W bits is exact because the true sum always fits.
        shift_sum = sum + SUM_W'(in_data) - SUM_W'(win[0]);
        fill_nx   = line_start ? FILL_W'(1) : ((fill == FILL_MAX) ? fill : fill + 1'b1);
        full_nx   = (fill_nx == FILL_MAX);
        // After the shift, the centre entry is the one currently one place above it.
        centre_nx = win[CTR+1];
        edge_nx   = 1'b0;
        if (!line_start && full_nx) begin
            if (mode)
                edge_nx = (shift_sum <= THRESH_V) && (centre_nx != '0);
            else
                edge_nx = (shift_sum > THRESH_V) && (centre_nx == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            sum        <= '0;
            fill       <= '0;
            next_col   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            edge_pulse <= 1'b0;
            edge_col   <= '0;
            edge_count <= '0;
        end else begin
            out_valid  <= in_valid;
            edge_pulse <= in_valid && edge_nx;
            if (in_valid) begin
                fill     <= fill_nx;
                next_col <= (cur_col == COL_MAX) ? cur_col : cur_col + 1'b1;
                if (line_start) begin
                    for (int i = 0; i < DEPTH - 1; i++) win[i] <= '0;
                    win[DEPTH-1] <= in_data;
                    sum          <= SUM_W'(in_data);
                    out_data     <= '0;
                    edge_count   <= '0;
                end else begin
                    for (int i = 0; i < DEPTH - 1; i++) win[i] <= win[i+1];
                    win[DEPTH-1] <= in_data;
                    sum          <= shift_sum;
                    out_data     <= win[0];
                    if (edge_nx) begin
                        edge_col <= cur_col - COL_W'(CTR);
                        if (edge_count != COL_MAX)
                            edge_count <= edge_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_window_edge_detector.sv
// tb/tb_window_edge_detector.sv - scoreboard bench for window_edge_detector
module tb_window_edge_detector;

    localparam int DATA_W  = 3;
    localparam int DEPTH   = 11;
    localparam int THRESH  = 3;
    localparam int COL_W   = 10;
    localparam int SUM_W   = DATA_W + $clog2(DEPTH);
    localparam int CTR     = DEPTH / 2;
    localparam int COL_MAX = (1 << COL_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              line_start;
    logic              mode;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [SUM_W-1:0]  sum;
    logic              window_full;
    logic              edge_pulse;
    logic [COL_W-1:0]  edge_col;
    logic [COL_W-1:0]  edge_count;

    window_edge_detector #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .THRESH(THRESH), .COL_W(COL_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .line_start(line_start), .mode(mode), .out_valid(out_valid),
        .out_data(out_data), .sum(sum), .window_full(window_full),
        .edge_pulse(edge_pulse), .edge_col(edge_col), .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int valid;
        int out_data;
        int sum;
        int full;
        int edge_p;
        int ecol;
        int ecount;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the samples of the current line, from which every output is derived.
    int hist[$];
    int m_out = 0, m_sum = 0, m_full = 0, m_ecol = 0, m_ecount = 0;

    function automatic void chk(string name, logic [31:0] act, int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endfunction

    task automatic step(input bit rst, input bit v, input bit ls, input bit md, input int d);
        exp_t e;
        reset      = rst;
        in_valid   = v;
        line_start = ls;
        mode       = md;
        in_data    = d[DATA_W-1:0];
        if (rst) begin
            hist.delete();
            m_out = 0; m_sum = 0; m_full = 0; m_ecol = 0; m_ecount = 0;
            e = '{0, 0, 0, 0, 0, 0, 0};
        end else if (!v) begin
            e = '{0, m_out, m_sum, m_full, 0, m_ecol, m_ecount};
        end else begin
            int n, col, centre, ep, lo;
            if (ls) begin
                hist.delete();
                m_ecount = 0;
            end
            n = hist.size();
            m_out = (n >= DEPTH) ? hist[n-DEPTH] : 0;
            hist.push_back(d & ((1 << DATA_W) - 1));
            n = n + 1;
            col = (n - 1 > COL_MAX) ? COL_MAX : n - 1;
            lo = (n > DEPTH) ? n - DEPTH : 0;
            m_sum = 0;
            for (int k = lo; k < n; k++) m_sum += hist[k];
            m_full = (n >= DEPTH) ? 1 : 0;
            centre = (n - 1 - CTR >= 0) ? hist[n-1-CTR] : 0;
            ep = 0;
            if (m_full == 1)
                ep = md ? ((m_sum <= THRESH && centre != 0) ? 1 : 0)
                        : ((m_sum > THRESH && centre == 0) ? 1 : 0);
            if (ep == 1) begin
                m_ecol = (col - CTR) & COL_MAX;
                if (m_ecount < COL_MAX) m_ecount++;
            end
            e = '{1, m_out, m_sum, m_full, ep, m_ecol, m_ecount};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation per clock, compared away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_out_valid", out_valid, e.valid);
                chk("sb_out_data", out_data, e.out_data);
                chk("sb_sum", sum, e.sum);
                chk("sb_window_full", window_full, e.full);
                chk("sb_edge", edge_pulse, e.edge_p);
                chk("sb_edge_col", edge_col, e.ecol);
                chk("sb_edge_count", edge_count, e.ecount);
            end
        end
    end

    int pat [DEPTH] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};

    initial begin
        bit md;
        reset = 1'b1; in_valid = 1'b0; line_start = 1'b0; mode = 1'b0; in_data = '0;

        step(1, 0, 0, 0, 0);
        chk("reset_sum", sum, 0);
        chk("reset_full", window_full, 0);
        chk("reset_edge_count", edge_count, 0);
        chk("reset_out_valid", out_valid, 0);

        // Flat window of ones: no edge anywhere.
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, i == 0, 0, 1);
            chk("ones_edge", edge_pulse, 0);
        end
        chk("ones_sum", sum, 11);
        chk("ones_full", window_full, 1);

        // Dark centre.
        for (int i = 0; i < DEPTH; i++) step(0, 1, i == 0, 0, pat[i]);
        chk("dark_sum", sum, 10);
        chk("dark_edge", edge_pulse, 1);
        chk("dark_edge_col", edge_col, 5);
        chk("dark_edge_count", edge_count, 1);

        // One sample short of a full window.
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(0, 1, i == 0, 0, pat[i]);
            chk("short_edge", edge_pulse, 0);
        end
        chk("short_full", window_full, 0);

        // Maximal samples with idle gaps.
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, i == 0, 0, 7);
            chk("gap_valid_after_accept", out_valid, 1);
            for (int g = 0; g < 3; g++) begin
                step(0, 0, 0, 0, 0);
                chk("gap_valid_idle", out_valid, 0);
                chk("gap_edge_idle", edge_pulse, 0);
            end
        end
        chk("gap_sum", sum, 77);
        chk("gap_full", window_full, 1);

        // Line start after a full window.
        for (int i = 0; i < DEPTH; i++) step(0, 1, i == 0, 0, 5);
        chk("fives_full", window_full, 1);
        step(0, 1, 1, 0, 2);
        chk("ls_sum", sum, 2);
        chk("ls_full", window_full, 0);
        chk("ls_edge_count", edge_count, 0);
        chk("ls_out_data", out_data, 0);
        chk("ls_out_valid", out_valid, 1);

        // Reset mid-stream overrides a valid line start.
        step(0, 1, 1, 0, 3);
        step(0, 1, 0, 0, 4);
        step(0, 1, 0, 0, 5);
        step(1, 1, 1, 0, 6);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sum", sum, 0);
        chk("rst_full", window_full, 0);
        chk("rst_edge", edge_pulse, 0);
        chk("rst_edge_col", edge_col, 0);
        chk("rst_edge_count", edge_count, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, pat[i]);
        chk("post_rst_edge", edge_pulse, 1);
        chk("post_rst_edge_col", edge_col, 5);
        chk("post_rst_edge_count", edge_count, 1);

        // Bright centre.
        for (int i = 0; i < DEPTH; i++) step(0, 1, i == 0, 1, (i == CTR) ? 1 : 0);
        chk("bright_sum", sum, 1);
        chk("bright_edge", edge_pulse, 1);
        chk("bright_edge_col", edge_col, 5);

        // Randomized traffic, scoreboard-checked.
        md = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int d;
            if ($urandom_range(0, 19) == 0) md = ~md;
            d = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 7);
            if (md && $urandom_range(0, 3) != 0) d = 0;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 29) == 0, md, d);
        end

        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
